// File: rtl/capture_scheduler.sv
// Trigger-driven ADC capture into a ring RAM, streamed out as one SD block.
// Optional CAPTURE_HEADER_EN prefixes each block with a 4-byte header.
module capture_scheduler #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int BLOCK_BYTES       = 512,
  parameter int PRE_TRIGGER       = 64,
  parameter int START_BLOCK       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                         sd_ready,
  output logic                         sd_start,
  output logic [31:0]                  sd_block_addr,
  output logic                         sd_axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] sd_axiod,
  input  logic                         sd_axiir,
  input  logic                         sd_done,
  output logic                         busy,
  output logic [15:0]                  blocks_written,
  output logic                         overflow
);

  localparam int SW = SAMPLE_DATA_WIDTH;
  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int CW = AW + 1;
`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam logic [CW-1:0] CAP_LEN = CW'(BLOCK_BYTES - HDR);
  localparam logic [CW-1:0] BLK_LEN = CW'(BLOCK_BYTES);
  localparam logic [CW-1:0] PRE_MAX = CW'(PRE_TRIGGER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_REQ,
    S_STREAM,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  start_ptr_q, start_ptr_d;
  logic [CW-1:0]  hist_cnt_q, hist_cnt_d;
  logic [CW-1:0]  cap_cnt_q, cap_cnt_d;
  logic [CW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic           trig_q;
  logic           sd_start_q, sd_start_d;
  logic           sd_axiov_q, sd_axiov_d;
  logic [SW-1:0]  sd_axiod_q, sd_axiod_d;
  logic [31:0]    addr_q, addr_d;
  logic [15:0]    blocks_q, blocks_d;
  logic           overflow_q, overflow_d;

  logic [SW-1:0]  mem [BLOCK_BYTES];
  logic [SW-1:0]  ram_q;
  logic           ram_we;
  logic           trig_edge;
  logic [SW-1:0]  ld_data;
  logic           ld_adv;

`ifdef CAPTURE_HEADER_EN
  logic [CW-1:0]  hist_lat_q, hist_lat_d;
  logic [SW-1:0]  hdr_byte;

  always_comb begin
    hdr_byte = '0;
    unique case (ld_cnt_q[1:0])
      2'd0: hdr_byte = SW'(blocks_q[15:8]);
      2'd1: hdr_byte = SW'(blocks_q[7:0]);
      2'd2: hdr_byte = SW'(8'hA5);
      2'd3: hdr_byte = SW'(8'(hist_lat_q));
    endcase
  end

  always_comb begin
    ld_adv  = ld_cnt_q >= CW'(HDR);
    ld_data = ld_adv ? ram_q : hdr_byte;
  end
`else
  always_comb begin
    ld_adv  = 1'b1;
    ld_data = ram_q;
  end
`endif

  // Read address tracks the next pointer so ram_q always holds mem[rd_ptr_q].
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q] <= axiid;
    end
    ram_q <= mem[rd_ptr_d];
  end

  assign trig_edge = trigger & ~trig_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    start_ptr_d = start_ptr_q;
    hist_cnt_d  = hist_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    sd_start_d  = 1'b0;
    sd_axiov_d  = sd_axiov_q;
    sd_axiod_d  = sd_axiod_q;
    addr_d      = addr_q;
    blocks_d    = blocks_q;
    overflow_d  = overflow_q;
    ram_we      = 1'b0;
`ifdef CAPTURE_HEADER_EN
    hist_lat_d  = hist_lat_q;
`endif
    if (trig_edge && state_q != S_IDLE) begin
      overflow_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (axiiv) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          hist_cnt_d = (hist_cnt_q >= PRE_MAX) ? PRE_MAX
                                               : hist_cnt_q + 1'b1;
        end
        if (trig_edge) begin
          start_ptr_d = wr_ptr_q - hist_cnt_q[AW-1:0];
          cap_cnt_d   = hist_cnt_q + CW'(axiiv);
`ifdef CAPTURE_HEADER_EN
          hist_lat_d  = hist_cnt_q;
`endif
          state_d = (cap_cnt_d >= CAP_LEN) ? S_REQ : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (axiiv) begin
          ram_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_d >= CAP_LEN) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (sd_ready) begin
          sd_start_d = 1'b1;
          rd_ptr_d   = start_ptr_q;
          ld_cnt_d   = '0;
          byte_cnt_d = '0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (sd_axiov_q && sd_axiir) begin
          sd_axiov_d = 1'b0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BLK_LEN - 1'b1) begin
            state_d = S_DONE;
          end
        end
        // Hold off one cycle after sd_start so the first byte lands 2 later.
        if (!sd_start_q && ld_cnt_q < BLK_LEN &&
            (!sd_axiov_q || sd_axiir)) begin
          sd_axiov_d = 1'b1;
          sd_axiod_d = ld_data;
          ld_cnt_d   = ld_cnt_q + 1'b1;
          if (ld_adv) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (sd_done) begin
          blocks_d   = blocks_q + 1'b1;
          addr_d     = addr_q + 1'b1;
          hist_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_ptr_q <= '0;
      hist_cnt_q  <= '0;
      cap_cnt_q   <= '0;
      ld_cnt_q    <= '0;
      byte_cnt_q  <= '0;
      trig_q      <= 1'b1;
      sd_start_q  <= 1'b0;
      sd_axiov_q  <= 1'b0;
      sd_axiod_q  <= '0;
      addr_q      <= 32'(START_BLOCK);
      blocks_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      start_ptr_q <= start_ptr_d;
      hist_cnt_q  <= hist_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      trig_q      <= trigger;
      sd_start_q  <= sd_start_d;
      sd_axiov_q  <= sd_axiov_d;
      sd_axiod_q  <= sd_axiod_d;
      addr_q      <= addr_d;
      blocks_q    <= blocks_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef CAPTURE_HEADER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_lat_q <= '0;
    end else begin
      hist_lat_q <= hist_lat_d;
    end
  end
`endif

  assign sd_start       = sd_start_q;
  assign sd_block_addr  = addr_q;
  assign sd_axiov       = sd_axiov_q;
  assign sd_axiod       = sd_axiod_q;
  assign busy           = state_q != S_IDLE;
  assign blocks_written = blocks_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Scoreboard bench for capture_scheduler: queued expected bytes/addresses
// are popped by a negedge monitor whenever the DUT transfers or starts.
module tb_capture_scheduler;

  localparam int W  = 8;
  localparam int BB = 16;
  localparam int PT = 4;
  localparam int SB = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trigger = 1'b0;
  logic         axiiv = 1'b0;
  logic [W-1:0] axiid = '0;
  logic         sd_ready = 1'b0;
  logic         sd_axiir = 1'b0;
  logic         sd_done = 1'b0;
  logic         sd_start;
  logic [31:0]  sd_block_addr;
  logic         sd_axiov;
  logic [W-1:0] sd_axiod;
  logic         busy;
  logic [15:0]  blocks_written;
  logic         overflow;

  capture_scheduler #(
    .SAMPLE_DATA_WIDTH(W),
    .BLOCK_BYTES(BB),
    .PRE_TRIGGER(PT),
    .START_BLOCK(SB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .axiiv(axiiv),
    .axiid(axiid),
    .sd_ready(sd_ready),
    .sd_start(sd_start),
    .sd_block_addr(sd_block_addr),
    .sd_axiov(sd_axiov),
    .sd_axiod(sd_axiod),
    .sd_axiir(sd_axiir),
    .sd_done(sd_done),
    .busy(busy),
    .blocks_written(blocks_written),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  bit need_gap = 1'b0;
  bit stall_prev = 1'b0;
  logic [W-1:0] od_prev = '0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  addr_exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(sd_axiov), 1);
        chk("stall_hold_data", 32'(sd_axiod), 32'(od_prev));
      end
      if (sd_start) begin
        start_cnt++;
        start_cyc = cyc;
        need_gap = 1'b1;
        if (addr_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: addr %0d", sd_block_addr);
        end else begin
          chk("block_addr", sd_block_addr, addr_exp_q.pop_front());
        end
      end
      if (sd_axiov && need_gap) begin
        need_gap = 1'b0;
        chk("start_to_valid_gap_ge2", 32'(cyc - start_cyc >= 2), 1);
      end
      if (sd_axiov && sd_axiir) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0d expected none", sd_axiod);
        end else begin
          chk("stream_byte", 32'(sd_axiod), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = sd_axiov & ~sd_axiir;
      od_prev = sd_axiod;
    end else begin
      stall_prev = 1'b0;
      need_gap = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    axiiv = 1'b1;
    axiid = W'(v);
    tick();
    axiiv = 1'b0;
  endtask

  task automatic push_block(input int first, input int addr);
    for (int i = 0; i < BB; i++) exp_q.push_back(W'(first + i));
    addr_exp_q.push_back(32'(addr));
  endtask

  task automatic wait_xfers(input int target, input int limit);
    int n;
    n = 0;
    while (xfer_cnt < target && n < limit) begin
      tick();
      n++;
    end
    chk("xfer_count", 32'(xfer_cnt), 32'(target));
  endtask

  task automatic finish_block(input int blk, input int addr);
    tick();
    chk("valid_low_after_last", 32'(sd_axiov), 0);
    chk("busy_in_done", 32'(busy), 1);
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    chk("blocks_written", 32'(blocks_written), 32'(blk));
    chk("next_block_addr", sd_block_addr, 32'(addr));
    chk("idle_after_done", 32'(busy), 0);
  endtask

  int base;
  int s0;

  initial begin
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sd_axiov", 32'(sd_axiov), 0);
    chk("rst_sd_start", 32'(sd_start), 0);
    chk("rst_blocks", 32'(blocks_written), 0);
    chk("rst_addr", sd_block_addr, SB);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // Block 1: pre-trigger history of 4, edge with sample 10.
    sd_ready = 1'b1;
    sd_axiir = 1'b1;
    push_block(6, SB);
    base = xfer_cnt;
    for (int v = 0; v <= 30; v++) begin
      trigger = (v == 10);
      send(v);
    end
    trigger = 1'b0;
    wait_xfers(base + BB, 100);
    finish_block(1, SB + 1);

    // sd_done outside DONE is ignored.
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    chk("done_ignored_in_idle", 32'(blocks_written), 1);

    // Block 2: only two history samples.
    push_block(0, SB + 1);
    base = xfer_cnt;
    send(0);
    send(1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int v = 2; v <= 20; v++) send(v);
    wait_xfers(base + BB, 100);
    finish_block(2, SB + 2);

    // Block 3: SD not ready for 50 cycles, then stalled stream.
    sd_ready = 1'b0;
    push_block(40, SB + 2);
    base = xfer_cnt;
    s0 = start_cnt;
    for (int v = 40; v <= 55; v++) begin
      trigger = (v == 40);
      send(v);
    end
    trigger = 1'b0;
    for (int i = 0; i < 50; i++) send(56 + i);
    chk("no_start_while_not_ready", 32'(start_cnt), 32'(s0));
    chk("busy_in_req", 32'(busy), 1);
    sd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (xfer_cnt >= base + BB) break;
      sd_axiir = ((i % 3) != 1);
      tick();
    end
    sd_axiir = 1'b1;
    chk("stalled_xfer_count", 32'(xfer_cnt), 32'(base + BB));
    finish_block(3, SB + 3);

    // Block 4: trigger edge during STREAM sets overflow.
    push_block(60, SB + 3);
    base = xfer_cnt;
    for (int v = 60; v <= 75; v++) begin
      trigger = (v == 60);
      send(v);
    end
    trigger = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sd_axiov) break;
      tick();
    end
    chk("stream_active", 32'(sd_axiov), 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("overflow_set", 32'(overflow), 1);
    wait_xfers(base + BB, 100);
    finish_block(4, SB + 4);
    chk("overflow_sticky", 32'(overflow), 1);

    // Block 5: reset mid-stream, trigger held high across release.
    push_block(80, SB + 4);
    base = xfer_cnt;
    for (int v = 80; v <= 95; v++) begin
      trigger = (v == 80);
      send(v);
    end
    trigger = 1'b0;
    chk("overflow_next_block", 32'(overflow), 1);
    wait_xfers(base + 7, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_axiov", 32'(sd_axiov), 0);
    chk("async_rst_busy", 32'(busy), 0);
    exp_q.delete();
    trigger = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("post_rst_blocks", 32'(blocks_written), 0);
    chk("post_rst_addr", sd_block_addr, SB);
    chk("post_rst_overflow", 32'(overflow), 0);
    s0 = start_cnt;
    for (int v = 0; v < 20; v++) send(v);
    chk("held_trigger_no_capture", 32'(busy), 0);
    chk("held_trigger_no_start", 32'(start_cnt), 32'(s0));
    trigger = 1'b0;
    tick();

    chk("exp_bytes_left", 32'(exp_q.size()), 0);
    chk("exp_addrs_left", 32'(addr_exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
- Sequences trigger-based capture of ADC samples into SD-card blocks.
- Input side: `adc_axiov`/`adc_axiod[9:2]` and the minmax_filter `triggered` output.
- In idle, keeps a rolling pre-trigger history. On a trigger edge, completes one block of samples, then owns the SD controller's block-write handshake while it streams the block out.
- Sits between the ADC/filter front end and `sd_card_controller`.

Parameters:
- SAMPLE_DATA_WIDTH, 8, width of samples and of SD bytes.
- BLOCK_BYTES, 512, entries per SD block. Power of two, at least 16.
- PRE_TRIGGER, 64, maximum history samples kept before the trigger. Must be less than BLOCK_BYTES.
- START_BLOCK, 0, first SD block address written after reset.

Ports:
- clk  input  1  system clock (sys_clk domain).
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  level from minmax_filter. Rising edge starts a capture.
- axiiv  input  1  sample valid.
- axiid  input  SAMPLE_DATA_WIDTH  sample data.
- sd_ready  input  1  SD controller idle and able to accept a block write.
- sd_start  output  1  one-cycle pulse requesting a block write.
- sd_block_addr  output  32  block address. Stable from sd_start until sd_done.
- sd_axiov  output  1  stream byte valid.
- sd_axiod  output  SAMPLE_DATA_WIDTH  stream byte.
- sd_axiir  input  1  SD controller ready for a byte.
- sd_done  input  1  one-cycle pulse when the block is committed.
- busy  output  1  high in every state except IDLE.
- blocks_written  output  16  count of committed blocks. Wraps at 65535 -> 0.
- overflow  output  1  sticky. Set when a trigger edge is missed.

Behaviour:
- Storage
  - Single ring RAM, BLOCK_BYTES deep, written only in IDLE and CAPTURE.
  - Pointers are log2(BLOCK_BYTES) bits and wrap modulo BLOCK_BYTES.
  - Synchronous read, 1-cycle latency.
- Reset (asynchronous; takes effect immediately, including mid-capture or mid-stream)
  - State = IDLE.
  - wr_ptr = 0; hist_cnt = 0; trigger edge register = 1, so a trigger already high at reset release is not an edge.
  - sd_start = 0, sd_axiov = 0, sd_axiod = 0, busy = 0, overflow = 0, blocks_written = 0.
  - sd_block_addr = START_BLOCK.
- Edge detect: trig_edge = trigger & ~trigger_q.
- IDLE
  - On each axiiv: write RAM[wr_ptr], advance wr_ptr, hist_cnt = min(hist_cnt+1, PRE_TRIGGER).
  - On trig_edge: start_ptr = wr_ptr - hist_cnt (mod BLOCK_BYTES); cap_cnt = hist_cnt; go to CAPTURE.
  - A sample with axiiv in the same cycle as trig_edge is written and counts as the first post-trigger sample, i.e. cap_cnt = hist_cnt + 1.
- CAPTURE
  - On each axiiv: write RAM[wr_ptr], advance wr_ptr, cap_cnt++.
  - When cap_cnt reaches BLOCK_BYTES (the sample that makes it BLOCK_BYTES is written): go to REQ.
- REQ
  - Incoming samples are dropped.
  - Wait for sd_ready. When seen, pulse sd_start for 1 cycle, set rd_ptr = start_ptr, byte_cnt = 0, go to STREAM.
- STREAM
  - sd_axiov asserts no earlier than 2 cycles after sd_start.
  - sd_axiod holds stable while sd_axiov & ~sd_axiir.
  - A transfer occurs when sd_axiov & sd_axiir. Prefetch so back-to-back transfers sustain one byte per clock.
  - Exactly BLOCK_BYTES transfers, starting at start_ptr, in capture order.
  - After the last transfer: sd_axiov = 0 next cycle; go to DONE.
- DONE
  - Wait for sd_done. Then blocks_written++, sd_block_addr++, hist_cnt = 0, go to IDLE.
  - sd_done in any other state is ignored.
- Overflow: any trig_edge outside IDLE sets overflow, which stays set until reset. State is unaffected.
- busy is combinational: state != IDLE.

Optional Feature:
- Macro: CAPTURE_HEADER_EN.
- When defined:
  - Each streamed block begins with 4 header bytes: blocks_written[15:8], blocks_written[7:0], 8'hA5, hist_cnt latched at trigger (truncated to 8 bits).
  - The header is followed by BLOCK_BYTES-4 samples. CAPTURE ends when cap_cnt reaches BLOCK_BYTES-4.
  - Total transfers remain BLOCK_BYTES.
- When undefined: no header; behaviour exactly as above.

Test Plan (BLOCK_BYTES=16, PRE_TRIGGER=4, START_BLOCK=100, macro undefined unless stated):
1. Feed samples 0..9 in IDLE, trigger edge alongside sample 10, then samples 11..30; sd_ready=1, sd_axiir=1 -> stream is bytes 6..21, exactly 16 transfers; after sd_done, blocks_written=1 and the first block used sd_block_addr=100, next is 101.
2. Trigger edge after only 2 samples (values 0,1), then samples 2..20 -> stream is 0..15; only 16 samples are stored.
3. Hold sd_ready=0 for 50 cycles after capture completes -> sd_start stays 0 and samples are dropped. Then toggle sd_axiir 1-0-1 during STREAM -> sd_axiod holds stable while stalled, no byte duplicated or skipped.
4. Trigger edge during STREAM -> overflow=1 and stays 1 through the next block; the stream is unchanged.
5. Assert rst mid-STREAM, at byte 7 -> sd_axiov=0 immediately (asynchronously); after release, busy=0, blocks_written=0, sd_block_addr=100. Trigger held high across reset release -> no capture starts.
6. With CAPTURE_HEADER_EN on the 2nd block -> first bytes are 00,01,A5,04, followed by 12 samples.
